// File: rtl/approx_mac_acc.sv
// Streaming signed dot-product accumulator with a one-entry result buffer.
// Define ACC_SAT_EN to clamp the accumulator; otherwise it wraps two's-complement.
module approx_mac_acc #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [15:0]      in_prod,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_ovf
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]        CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                  state_r;
  state_t                  next_state_s;
  logic signed [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    ovf_run_r;
  logic                    out_valid_r;
  logic signed [ACC_W-1:0] out_acc_r;
  logic [CNT_W-1:0]        out_count_r;
  logic                    out_ovf_r;

  logic                    in_ready_s;
  logic                    accept_s;
  logic                    out_hs_s;
  logic signed [ACC_W-1:0] acc_base_s;
  logic signed [ACC_W:0]   sum_wide_s;
  logic                    arith_ovf_s;
  logic signed [ACC_W-1:0] sum_res_s;
  logic [CNT_W-1:0]        cnt_next_s;
  logic                    cnt_sat_s;
  logic                    ovf_next_s;

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_acc   = out_acc_r;
  assign out_count = out_count_r;
  assign out_ovf   = out_ovf_r;

  assign accept_s = in_valid & in_ready_s;
  assign out_hs_s = out_valid_r & out_ready;

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic: a last beat always closes the vector
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !in_last) begin
          next_state_s = ACCUM;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s && in_last) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = ACCUM;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM outputs: handshake ready and the accumulation base for the next beat
  always_comb begin
    in_ready_s = reset_n & (~out_valid_r | out_ready);
    acc_base_s = acc_r;
    case (state_r)
      IDLE:    acc_base_s = '0;
      ACCUM:   acc_base_s = acc_r;
      default: acc_base_s = '0;
    endcase
  end

  // Widened sum: top two bits disagree exactly when the signed add overflows
  always_comb begin
    sum_wide_s  = {acc_base_s[ACC_W-1], acc_base_s}
                + {{(ACC_W+1-16){in_prod[15]}}, in_prod};
    arith_ovf_s = sum_wide_s[ACC_W] ^ sum_wide_s[ACC_W-1];
`ifdef ACC_SAT_EN
    if (arith_ovf_s) begin
      sum_res_s = sum_wide_s[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_res_s = sum_wide_s[ACC_W-1:0];
    end
`else
    sum_res_s = sum_wide_s[ACC_W-1:0];
`endif
  end

  // Element counter saturates at its maximum and flags the overflow
  always_comb begin
    if (cnt_r == CNT_MAX) begin
      cnt_next_s = cnt_r;
      cnt_sat_s  = 1'b1;
    end else begin
      cnt_next_s = cnt_r + CNT_ONE;
      cnt_sat_s  = 1'b0;
    end
    ovf_next_s = ovf_run_r | arith_ovf_s | cnt_sat_s;
  end

  // Running accumulator state, cleared when a vector completes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_r     <= '0;
      cnt_r     <= '0;
      ovf_run_r <= 1'b0;
    end else if (accept_s) begin
      if (in_last) begin
        acc_r     <= '0;
        cnt_r     <= '0;
        ovf_run_r <= 1'b0;
      end else begin
        acc_r     <= sum_res_s;
        cnt_r     <= cnt_next_s;
        ovf_run_r <= ovf_next_s;
      end
    end else begin
      acc_r     <= acc_r;
      cnt_r     <= cnt_r;
      ovf_run_r <= ovf_run_r;
    end
  end

  // One-entry result buffer; a reload in the draining cycle keeps it full
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      out_acc_r   <= '0;
      out_count_r <= '0;
      out_ovf_r   <= 1'b0;
    end else if (accept_s && in_last) begin
      out_valid_r <= 1'b1;
      out_acc_r   <= sum_res_s;
      out_count_r <= cnt_next_s;
      out_ovf_r   <= ovf_next_s;
    end else if (out_hs_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: tb/tb_approx_mac_acc.sv
// Self-checking bench: a default-width and a narrow (ACC_W=17, CNT_W=2) instance
// share one input stream and are checked against an arithmetic reference model.
module tb_approx_mac_acc;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic               reset_n;
  logic               in_valid;
  logic               in_last;
  logic               out_ready;
  logic signed [15:0] in_prod;

  logic               rdy_a, vld_a, ovf_a;
  logic signed [23:0] acc_a;
  logic [7:0]         cnt_a;
  logic               rdy_b, vld_b, ovf_b;
  logic signed [16:0] acc_b;
  logic [1:0]         cnt_b;

  approx_mac_acc #(.ACC_W(24), .CNT_W(8)) dut_a (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_a),
    .in_prod(in_prod), .in_last(in_last), .out_valid(vld_a), .out_ready(out_ready),
    .out_acc(acc_a), .out_count(cnt_a), .out_ovf(ovf_a)
  );

  approx_mac_acc #(.ACC_W(17), .CNT_W(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_b),
    .in_prod(in_prod), .in_last(in_last), .out_valid(vld_b), .out_ready(out_ready),
    .out_acc(acc_b), .out_count(cnt_b), .out_ovf(ovf_b)
  );

  typedef struct {
    longint a24; longint c8; bit o24;
    longint a17; longint c2; bit o17;
  } res_t;

  int   total = 0;
  int   bad   = 0;
  res_t exp_q[$];
  int   beats[$];

  task automatic chk(input string tag, input logic signed [63:0] obs, input longint expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: plain integer sum with clamp or modular wrap, saturating count
  function automatic void model(input int b[$], input int aw, input int cw,
                                output longint a, output longint c, output bit o);
    longint maxv, minv, s, cmax;
    maxv = (64'sd1 <<< (aw - 1)) - 64'sd1;
    minv = -(64'sd1 <<< (aw - 1));
    cmax = (64'sd1 <<< cw) - 64'sd1;
    a = 0; c = 0; o = 1'b0;
    foreach (b[i]) begin
      s = a + longint'(b[i]);
`ifdef ACC_SAT_EN
      if (s > maxv) begin s = maxv; o = 1'b1; end
      else if (s < minv) begin s = minv; o = 1'b1; end
`else
      if (s > maxv) begin s = s - (64'sd1 <<< aw); o = 1'b1; end
      else if (s < minv) begin s = s + (64'sd1 <<< aw); o = 1'b1; end
`endif
      a = s;
      if (c == cmax) o = 1'b1;
      else c = c + 1;
    end
  endfunction

  task automatic monitor();
    bit   ev, er, acc;
    res_t r;
    ev  = (exp_q.size() != 0);
    er  = !ev || out_ready;
    acc = in_valid && er;
    chk("valid_a", vld_a, ev);
    chk("valid_b", vld_b, ev);
    chk("ready_a", rdy_a, er);
    chk("ready_b", rdy_b, er);
    if (ev) begin
      chk("acc_a", acc_a, exp_q[0].a24);
      chk("cnt_a", cnt_a, exp_q[0].c8);
      chk("ovf_a", ovf_a, exp_q[0].o24);
      chk("acc_b", acc_b, exp_q[0].a17);
      chk("cnt_b", cnt_b, exp_q[0].c2);
      chk("ovf_b", ovf_b, exp_q[0].o17);
      if (out_ready) void'(exp_q.pop_front());
    end
    if (acc) begin
      beats.push_back(int'(in_prod));
      if (in_last) begin
        model(beats, 24, 8, r.a24, r.c8, r.o24);
        model(beats, 17, 2, r.a17, r.c2, r.o17);
        exp_q.push_back(r);
        beats.delete();
      end
    end
  endtask

  task automatic step(input logic v, input logic signed [15:0] p, input logic l, input logic ordy);
    @(negedge clock);
    in_valid  = v;
    in_prod   = p;
    in_last   = l;
    out_ready = ordy;
    #1;
    monitor();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_valid", vld_a | vld_b, 0);
    chk("rst_ready", rdy_a | rdy_b, 0);
    chk("rst_acc_a", acc_a, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_ovf_b", ovf_b, 0);
    exp_q.delete();
    beats.delete();
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready_a", rdy_a, 1);
    chk("post_rst_ready_b", rdy_b, 1);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_prod   = 16'sd0;
    out_ready = 1'b1;
    do_reset();

    // Basic vector
    step(1'b1, 16'sd100, 1'b0, 1'b1);
    step(1'b1, -16'sd37, 1'b0, 1'b1);
    step(1'b1, 16'sd5,   1'b1, 1'b1);
    step(1'b0, 16'sd0,   1'b0, 1'b1);
    chk("tp1_acc", acc_a, 68);
    chk("tp1_cnt", cnt_a, 3);
    chk("tp1_ovf", ovf_a, 0);

    // Single beat held under backpressure
    step(1'b1, -16'sd16384, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'sd9, 1'b1, 1'b0);
      chk("tp2_ready", rdy_a, 0);
      chk("tp2_acc", acc_a, -16384);
      chk("tp2_cnt", cnt_a, 1);
    end
    step(1'b1, 16'sd9, 1'b1, 1'b1);
    step(1'b0, 16'sd0, 1'b0, 1'b1);
    chk("tp2_next_acc", acc_a, 9);

    // Back-to-back vectors
    step(1'b1, 16'sd1, 1'b0, 1'b1);
    step(1'b1, 16'sd2, 1'b1, 1'b1);
    step(1'b1, 16'sd3, 1'b1, 1'b1);
    chk("tp3_first_acc", acc_a, 3);
    chk("tp3_first_cnt", cnt_a, 2);
    step(1'b0, 16'sd0, 1'b0, 1'b1);
    chk("tp3_second_valid", vld_a, 1);
    chk("tp3_second_acc", acc_a, 3);
    chk("tp3_second_cnt", cnt_a, 1);
    step(1'b0, 16'sd0, 1'b0, 1'b1);

    // Accumulator overflow on the narrow instance
    step(1'b1, 16'sd32767, 1'b0, 1'b1);
    step(1'b1, 16'sd32767, 1'b0, 1'b1);
    step(1'b1, 16'sd32767, 1'b1, 1'b1);
    step(1'b0, 16'sd0, 1'b0, 1'b1);
    chk("tp4_acc_a", acc_a, 98301);
    chk("tp4_ovf_a", ovf_a, 0);
`ifdef ACC_SAT_EN
    chk("tp4_acc_b", acc_b, 65535);
`else
    chk("tp4_acc_b", acc_b, -32771);
`endif
    chk("tp4_ovf_b", ovf_b, 1);

    // Count overflow on the narrow instance
    for (int i = 0; i < 5; i++) step(1'b1, 16'sd1, (i == 4), 1'b1);
    step(1'b0, 16'sd0, 1'b0, 1'b1);
    chk("tp5_cnt_b", cnt_b, 3);
    chk("tp5_ovf_b", ovf_b, 1);
    chk("tp5_acc_b", acc_b, 5);
    chk("tp5_cnt_a", cnt_a, 5);

    // Reset mid-vector discards partial data
    step(1'b1, 16'sd10, 1'b0, 1'b1);
    step(1'b1, 16'sd20, 1'b0, 1'b1);
    do_reset();
    step(1'b1, 16'sd7, 1'b1, 1'b1);
    step(1'b0, 16'sd0, 1'b0, 1'b1);
    chk("tp6_acc", acc_a, 7);
    chk("tp6_cnt", cnt_a, 1);

    // Randomized traffic with extreme products and random backpressure
    for (int i = 0; i < 800; i++) begin
      logic signed [15:0] p;
      if ($urandom_range(0, 3) == 0) p = ($urandom_range(0, 1) == 1) ? 16'sh7fff : 16'sh8000;
      else p = 16'($urandom);
      step(($urandom_range(0, 3) != 0), p, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 16'sd0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/approx_mac_acc.md
# approx_mac_acc

Streaming signed accumulator that sits directly downstream of the 8x8 signed approximate multipliers (16-bit signed product O). It consumes one product per cycle under a valid/ready handshake and sums the products of one vector, delimited by a last flag, into a wide accumulator. It presents the dot-product result, element count and overflow flag through a one-entry output buffer with its own valid/ready handshake.

## Interface
- ACC_W, 24: accumulator and result width in bits, signed; legal range 17..32.
- CNT_W, 8: element-counter width; maximum vector length is 2^CNT_W - 1.

- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_prod and in_last are valid this cycle.
- in_ready  out  1  block accepts a beat this cycle.
- in_prod  in  16  signed product from the multiplier.
- in_last  in  1  the beat is the final element of the vector.
- out_valid  out  1  result buffer is full.
- out_ready  in  1  consumer takes the result this cycle.
- out_acc  out  ACC_W  signed dot-product result.
- out_count  out  CNT_W  number of elements summed into out_acc.
- out_ovf  out  1  arithmetic or count overflow occurred in this vector.

## Operation
- A beat is accepted when in_valid & in_ready.
- in_ready = !out_valid | out_ready. It is forced to 0 while reset_n is low.
- Internal state: acc (ACC_W), cnt (CNT_W), ovf_run (sticky flag). FSM has two states:
  - IDLE: cnt == 0.
  - ACCUM: at least one beat of the current vector has been accepted.
- Accepted beat:
  - next = acc + sign_extend(in_prod).
  - next is resolved per Configuration; ovf_run is set if overflow occurs.
  - cnt increments. At cnt == 2^CNT_W - 1, cnt holds and ovf_run is set.
- Accepted beat with in_last:
  - The resolved sum, the updated count and the updated overflow flag load into the out_* registers, and out_valid sets.
  - acc, cnt and ovf_run clear to 0; the FSM goes to IDLE.
  - A single-beat vector (in_last on the first beat) is legal and gives out_count = 1.
- Accepted beat without in_last: acc, cnt and ovf_run update; the FSM is in ACCUM.
- Output handshake out_valid & out_ready: out_valid clears, unless a last beat is accepted in the same cycle, in which case the buffer reloads and out_valid stays 1.
- out_acc, out_count and out_ovf are stable while out_valid & !out_ready.
- Non-last beats are accepted whenever in_ready is high, including while the previous result is waiting.
- in_valid low: no state change.
- in_prod is ignored when no beat is accepted.

## Timing
- Reset (asynchronous, reset_n low): acc, cnt, ovf_run, out_acc, out_count and out_ovf are 0; out_valid is 0; FSM is IDLE.
- After reset_n deasserts, in_ready is 1 in the first cycle.
- Reset mid-vector or with a pending result discards all partial and pending data.
- Latency: out_valid is high in the cycle after the last beat is accepted.
- Throughput: one beat per cycle sustained when out_ready stays 1. Back-to-back vectors need no bubble.
- Backpressure: with out_valid = 1 and out_ready = 0, in_ready is 0 and no beat is accepted.
- in_ready depends combinationally on out_ready only. There is no other combinational input-to-output path.

## Configuration
- ACC_SAT_EN defined:
  - A result above 2^(ACC_W-1) - 1 clamps to 2^(ACC_W-1) - 1.
  - A result below -2^(ACC_W-1) clamps to -2^(ACC_W-1).
  - A clamp sets ovf_run.
  - Accumulation continues from the clamped value.
- ACC_SAT_EN undefined:
  - Two's-complement wrap modulo 2^ACC_W.
  - Signed overflow (operand signs equal, sum sign differs) still sets ovf_run.

## Test plan
- Reset, then beats 100, -37, 5 (last on 5) with out_ready = 1 -> in the cycle after the last beat: out_valid = 1, out_acc = 68, out_count = 3, out_ovf = 0.
- Single beat -16384 with last, out_ready held 0 for 5 cycles -> out_acc = -16384 and out_count = 1 stay stable; in_ready = 0 for those 5 cycles; out_ready = 1 releases it.
- Two vectors back to back, {1, 2 last} then {3 last}, out_ready = 1 -> no bubble; results 3 then 3, on consecutive output cycles.
- ACC_W = 17, beats 32767 x 3 (last on the third):
  - With ACC_SAT_EN: out_acc = 65535, out_ovf = 1.
  - Without ACC_SAT_EN: out_acc = -32771, out_ovf = 1.
- CNT_W = 2, five beats of 1 (last on the fifth) -> out_count = 3, out_ovf = 1, out_acc = 5.
- reset_n pulsed low mid-vector after beats 10, 20 -> out_valid = 0; then beat 7 with last -> out_acc = 7, out_count = 1.
